dmem_arbiter: RTL

- Shares the single-port data memory between two requesters: the CPU data port (port 0) and a DMA/display fetch engine (port 1).
- Sits between the CPU/DMA address decode and the dmem instance, and takes over the dmem address, write-data and write-enable drive.
- Policy is fixed CPU priority, with a starvation counter that forces a DMA grant after a bounded wait.
- Read data is routed back to the issuing port with a registered valid strobe.

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/dmem_arbiter_if.sv | 51 +++++
 rtl/dmem_arb_starve_cnt.sv | 53 +++++
 rtl/dmem_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: owner encodings, default
// widths, default starvation limit and the per-port request bundle.
package dmem_arb_pkg;

  localparam int ARB_ADDR_W       = 11;
  localparam int ARB_DATA_W       = 32;
  localparam int DEF_STARVE_LIMIT = 4;

  // Read-return owner encoding
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  // One requester's access bundle, sized by the default widths above
  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } arb_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the arbiter and the dmem.
// The arbiter uses the slave modport; requesters plus the memory side use
// the master modport.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);

  // CPU data port (port 0)
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  // DMA/display fetch port (port 1)
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;

  // Single-port dmem drive
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rdata, cpu_rvalid,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rdata, cpu_rvalid,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arb_starve_cnt.sv
// DMA starvation counter: counts consecutive cycles in which DMA asks but
// is not granted, saturating at STARVE_LIMIT. force_dma_o tells the grant
// logic that DMA must win the next conflict.
module dmem_arb_starve_cnt #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic dma_req_i,
  input  logic dma_gnt_i,
  output logic force_dma_o
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_limit;

  // A zero limit means DMA always wins; skip the compare entirely there
  generate
    if (STARVE_LIMIT == 0) begin : g_always_force
      assign at_limit = 1'b1;
    end else begin : g_compare
      assign at_limit = (cnt_q >= LIMIT_C);
    end
  endgenerate

  assign force_dma_o = at_limit;

  // Next count: clear on grant or idle, otherwise saturating increment
  always_comb begin
    cnt_d = cnt_q;
    if (!dma_req_i || dma_gnt_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (!at_limit) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory. CPU has fixed priority;
// the starvation counter forces a DMA grant after a bounded wait. Grants and
// the dmem drive are combinational; read data returns one cycle after the
// grant with a registered valid strobe for the issuing port.
// Optional build macro: DMEM_ARB_STATS_EN adds grant/conflict counters and a
// request-stability assertion.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = ARB_ADDR_W,
  parameter int DATA_W       = ARB_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int CNT_W        = 3
) (
  input  logic              clk,
  input  logic              reset,
  dmem_arbiter_if.slave     bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [DATA_W-1:0] stat_cpu_grants,
  output logic [DATA_W-1:0] stat_dma_grants,
  output logic [DATA_W-1:0] stat_conflicts
`endif
);

  // The request bundle carries package widths; ADDR_W/DATA_W track them.
  arb_req_t cpu_rq;
  arb_req_t dma_rq;
  arb_req_t win_rq;

  logic cpu_gnt;
  logic dma_gnt;
  logic force_dma;

  logic rd_pend_q;
  logic rd_pend_d;
  logic rd_owner_q;
  logic rd_owner_d;
  logic cpu_rvalid_q;
  logic cpu_rvalid_d;
  logic dma_rvalid_q;
  logic dma_rvalid_d;

  assign cpu_rq = '{req: bus.cpu_req, we: bus.cpu_we, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
  assign dma_rq = '{req: bus.dma_req, we: bus.dma_we, addr: bus.dma_addr, wdata: bus.dma_wdata};

  dmem_arb_starve_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_starve_cnt (
    .clk         (clk),
    .reset       (reset),
    .dma_req_i   (bus.dma_req),
    .dma_gnt_i   (dma_gnt),
    .force_dma_o (force_dma)
  );

  // Grant decision: CPU priority unless the starvation counter forces DMA
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (reset) begin
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
    end else if (cpu_rq.req && dma_rq.req) begin
      if (force_dma) begin
        dma_gnt = 1'b1;
      end else begin
        cpu_gnt = 1'b1;
      end
    end else if (cpu_rq.req) begin
      cpu_gnt = 1'b1;
    end else if (dma_rq.req) begin
      dma_gnt = 1'b1;
    end else begin
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
    end
  end

  // dmem drive follows the winner; idle cycles drive all zeros
  always_comb begin
    win_rq = '0;
    if (cpu_gnt) begin
      win_rq = cpu_rq;
    end else if (dma_gnt) begin
      win_rq = dma_rq;
    end else begin
      win_rq = '0;
    end
  end

  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.dma_gnt   = dma_gnt;
  assign bus.mem_addr  = win_rq.addr;
  assign bus.mem_wdata = win_rq.wdata;
  assign bus.mem_we    = win_rq.we & (cpu_gnt | dma_gnt);

  // Read-return next state: a granted read marks the owner for next cycle
  always_comb begin
    rd_pend_d    = (cpu_gnt | dma_gnt) & ~win_rq.we;
    rd_owner_d   = rd_owner_q;
    if (rd_pend_d) begin
      rd_owner_d = dma_gnt ? PORT_DMA : PORT_CPU;
    end else begin
      rd_owner_d = rd_owner_q;
    end
    cpu_rvalid_d = rd_pend_d & (rd_owner_d == PORT_CPU);
    dma_rvalid_d = rd_pend_d & (rd_owner_d == PORT_DMA);
  end

  // Read-return pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= PORT_CPU;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
    end else begin
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

  // Both ports see the memory data; only rvalid qualifies it
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.dma_rdata  = bus.mem_rdata;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.dma_rvalid = dma_rvalid_q;

`ifdef DMEM_ARB_STATS_EN
  logic [DATA_W-1:0] st_cpu_q;
  logic [DATA_W-1:0] st_dma_q;
  logic [DATA_W-1:0] st_cfl_q;

  // Saturating grant and conflict counters
  always_ff @(posedge clk) begin
    if (reset) begin
      st_cpu_q <= {DATA_W{1'b0}};
      st_dma_q <= {DATA_W{1'b0}};
      st_cfl_q <= {DATA_W{1'b0}};
    end else begin
      if (cpu_gnt && (st_cpu_q != {DATA_W{1'b1}})) begin
        st_cpu_q <= st_cpu_q + {{(DATA_W-1){1'b0}}, 1'b1};
      end
      if (dma_gnt && (st_dma_q != {DATA_W{1'b1}})) begin
        st_dma_q <= st_dma_q + {{(DATA_W-1){1'b0}}, 1'b1};
      end
      if (cpu_rq.req && dma_rq.req && (st_cfl_q != {DATA_W{1'b1}})) begin
        st_cfl_q <= st_cfl_q + {{(DATA_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign stat_cpu_grants = st_cpu_q;
  assign stat_dma_grants = st_dma_q;
  assign stat_conflicts  = st_cfl_q;

`ifndef SYNTHESIS
  // A waiting requester must hold its access fields until granted
  a_cpu_hold: assert property (@(posedge clk) disable iff (reset)
    (bus.cpu_req && !cpu_gnt) |=>
      ($stable(bus.cpu_we) && $stable(bus.cpu_addr) && $stable(bus.cpu_wdata)));
  a_dma_hold: assert property (@(posedge clk) disable iff (reset)
    (bus.dma_req && !dma_gnt) |=>
      ($stable(bus.dma_we) && $stable(bus.dma_addr) && $stable(bus.dma_wdata)));
`endif
`endif

endmodule
